// File: rtl/gpio_pad_pkg.sv
// gpio_pad_pkg: shared sequencer state encoding, default timing constants and step ordering helper
package gpio_pad_pkg;

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_EN_H    = 3'd1,
        S_EN_RAIL = 3'd2,
        S_EN_INP  = 3'd3,
        S_ACTIVE  = 3'd4,
        S_HOLD    = 3'd5
    } pad_seq_state_t;

    localparam int DEF_SEQ_STEP_CYCLES = 16;
    localparam int DEF_DEB_CYCLES      = 8;

    // Power-up step that follows a timed step once its dwell time has elapsed
    function automatic pad_seq_state_t seq_next(input pad_seq_state_t s);
        case (s)
            S_EN_H:    return S_EN_RAIL;
            S_EN_RAIL: return S_EN_INP;
            S_EN_INP:  return S_ACTIVE;
            default:   return S_OFF;
        endcase
    endfunction

endpackage

// File: rtl/gpio_in_deb.sv
// gpio_in_deb: two-flop synchronizer and debounce filter for one asynchronous pad input
module gpio_in_deb
    import gpio_pad_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic pad_in,
    output logic core_in
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Synchronize, then accept a new level only after DEB_CYCLES differing samples in a row
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            cnt     <= '0;
            core_in <= 1'b0;
        end else begin
            s1 <= pad_in;
            s2 <= s1;
            if (s2 == core_in) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                core_in <= s2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: pad bank power-up sequencer, hold latch control, output drive and debounced input return
module gpio_pad_ctrl
    import gpio_pad_pkg::*;
#(
    parameter int N_PADS          = 8,
    parameter int SEQ_STEP_CYCLES = DEF_SEQ_STEP_CYCLES,
    parameter int DEB_CYCLES      = DEF_DEB_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwr_good,
    input  logic              hold_req,
    input  logic [N_PADS-1:0] core_out,
    input  logic [N_PADS-1:0] core_oe,
    output logic [N_PADS-1:0] core_in,
    output logic [N_PADS-1:0] pad_do,
    output logic [N_PADS-1:0] pad_oe,
    input  logic [N_PADS-1:0] pad_in,
    output logic              enable_h,
    output logic              enable_vdda_h,
    output logic              enable_vswitch_h,
    output logic              enable_vddio,
    output logic              enable_inp_h,
    output logic              hold_h,
    output logic              ready
);

    localparam int SW = $clog2(SEQ_STEP_CYCLES + 1);

    pad_seq_state_t state;
    pad_seq_state_t state_nxt;
    logic [SW-1:0]  step_cnt;
    logic [SW-1:0]  step_cnt_nxt;
    logic           step_done;
    logic           rail_on;
    logic           inp_on;

    assign step_done = step_cnt == SW'(SEQ_STEP_CYCLES - 1);
    assign rail_on   = state_nxt inside {S_EN_RAIL, S_EN_INP, S_ACTIVE, S_HOLD};
    assign inp_on    = state_nxt inside {S_EN_INP, S_ACTIVE, S_HOLD};

    // Next state: supply loss wins over everything, timed steps advance when the dwell counter expires
    always_comb begin
        state_nxt    = state;
        step_cnt_nxt = '0;
        if (!pwr_good) begin
            state_nxt = S_OFF;
        end else begin
            case (state)
                S_OFF: state_nxt = S_EN_H;
                S_EN_H, S_EN_RAIL, S_EN_INP: begin
                    state_nxt    = step_done ? seq_next(state) : state;
                    step_cnt_nxt = step_done ? '0 : step_cnt + SW'(1);
                end
                S_ACTIVE: state_nxt = hold_req ? S_HOLD : S_ACTIVE;
                S_HOLD:   state_nxt = hold_req ? S_HOLD : S_ACTIVE;
                default:  state_nxt = S_OFF;
            endcase
        end
    end

    // State, step counter and registered rail/hold/ready outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_OFF;
            step_cnt         <= '0;
            enable_h         <= 1'b0;
            enable_vdda_h    <= 1'b0;
            enable_vswitch_h <= 1'b0;
            enable_vddio     <= 1'b0;
            enable_inp_h     <= 1'b0;
            hold_h           <= 1'b1;
            ready            <= 1'b0;
        end else begin
            state            <= state_nxt;
            step_cnt         <= step_cnt_nxt;
            enable_h         <= state_nxt != S_OFF;
            enable_vdda_h    <= rail_on;
            enable_vswitch_h <= rail_on;
            enable_vddio     <= rail_on;
            enable_inp_h     <= inp_on;
            hold_h           <= state_nxt != S_HOLD;
            ready            <= state_nxt == S_ACTIVE;
        end
    end

    // Pad drive follows the core only while ACTIVE; it freezes in HOLD and clears on supply loss
    always_ff @(posedge clk) begin
        if (!rst_n || !pwr_good) begin
            pad_do <= '0;
            pad_oe <= '0;
        end else if (state == S_ACTIVE) begin
            pad_do <= core_out;
            pad_oe <= core_oe;
        end
    end

    for (genvar g = 0; g < N_PADS; g++) begin : g_pad
        gpio_in_deb #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (enable_inp_h),
            .pad_in (pad_in[g]),
            .core_in(core_in[g])
        );
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: vector table, directed corner sequences and randomized run against a behavioural model
module tb_gpio_pad_ctrl;

    localparam int N    = 8;
    localparam int STEP = 16;
    localparam int DEB  = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pwr_good = 1'b0;
    logic         hold_req = 1'b0;
    logic [N-1:0] core_out = '0;
    logic [N-1:0] core_oe = '0;
    logic [N-1:0] pad_in = '0;
    logic [N-1:0] core_in;
    logic [N-1:0] pad_do;
    logic [N-1:0] pad_oe;
    logic         enable_h;
    logic         enable_vdda_h;
    logic         enable_vswitch_h;
    logic         enable_vddio;
    logic         enable_inp_h;
    logic         hold_h;
    logic         ready;

    int n_total = 0;
    int n_pass  = 0;

    gpio_pad_ctrl #(
        .N_PADS(N),
        .SEQ_STEP_CYCLES(STEP),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pwr_good        (pwr_good),
        .hold_req        (hold_req),
        .core_out        (core_out),
        .core_oe         (core_oe),
        .core_in         (core_in),
        .pad_do          (pad_do),
        .pad_oe          (pad_oe),
        .pad_in          (pad_in),
        .enable_h        (enable_h),
        .enable_vdda_h   (enable_vdda_h),
        .enable_vswitch_h(enable_vswitch_h),
        .enable_vddio    (enable_vddio),
        .enable_inp_h    (enable_inp_h),
        .hold_h          (hold_h),
        .ready           (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Behavioural model: sequence position as elapsed cycles since EN_H entry, debounce as a sliding window
    typedef struct packed {
        logic         en;
        logic [N-1:0] s2;
    } hist_t;

    bit           m_on;
    int           m_seq;
    bit           m_hold;
    logic [N-1:0] m_do, m_oe, m_s1, m_s2, m_q;
    hist_t        hist[$];

    function automatic logic [6:0] model_stat();
        bit act;
        act = m_on && m_seq >= 3 * STEP;
        return {m_on, {3{m_on && m_seq >= STEP}}, m_on && m_seq >= 2 * STEP, !(act && m_hold), act && !m_hold};
    endfunction

    task automatic model_edge();
        bit en_prev;
        bit all;
        en_prev = m_on && m_seq >= 2 * STEP;
        if (!rst_n) begin
            m_on = 0; m_seq = 0; m_hold = 0;
            m_do = '0; m_oe = '0; m_s1 = '0; m_s2 = '0; m_q = '0;
            hist.delete();
        end else begin
            hist.push_back('{en: en_prev, s2: m_s2});
            if (hist.size() > DEB) void'(hist.pop_front());
            if (!en_prev) m_q = '0;
            else for (int p = 0; p < N; p++) begin
                all = hist.size() == DEB;
                foreach (hist[i]) if (!hist[i].en || hist[i].s2[p] == m_q[p]) all = 0;
                if (all) m_q[p] = ~m_q[p];
            end
            m_s2 = en_prev ? m_s1 : '0;
            m_s1 = en_prev ? pad_in : '0;
            if (!pwr_good) begin
                m_on = 0; m_seq = 0; m_hold = 0; m_do = '0; m_oe = '0;
            end else if (!m_on) begin
                m_on = 1; m_seq = 0;
            end else if (m_seq < 3 * STEP) begin
                m_seq++;
            end else begin
                if (!m_hold) begin
                    m_do = core_out;
                    m_oe = core_oe;
                end
                m_hold = hold_req;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("stat", {enable_h, enable_vdda_h, enable_vswitch_h, enable_vddio, enable_inp_h, hold_h, ready}, 32'(model_stat()));
        chk("pad_do", 32'(pad_do), 32'(m_do));
        chk("pad_oe", 32'(pad_oe), 32'(m_oe));
        chk("core_in", 32'(core_in), 32'(m_q));
    endtask

    typedef struct {
        logic [N-1:0] co;
        logic [N-1:0] oe;
        logic         hr;
        logic [N-1:0] edo;
        logic [N-1:0] eoe;
        logic         ehh;
        logic         erdy;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int e_h, e_rail, e_inp, e_rdy, first;
        tbl[0] = '{8'hA5, 8'h0F, 1'b0, 8'hA5, 8'h0F, 1'b1, 1'b1};
        tbl[1] = '{8'hA5, 8'h0F, 1'b1, 8'hA5, 8'h0F, 1'b0, 1'b0};
        tbl[2] = '{8'h3C, 8'hF0, 1'b1, 8'hA5, 8'h0F, 1'b0, 1'b0};
        tbl[3] = '{8'h3C, 8'hF0, 1'b0, 8'hA5, 8'h0F, 1'b1, 1'b1};
        tbl[4] = '{8'h3C, 8'hF0, 1'b0, 8'h3C, 8'hF0, 1'b1, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1};
        tbl[6] = '{8'h00, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1};

        cyc();
        cyc();
        chk("rst_stat", {enable_h, enable_vdda_h, enable_vswitch_h, enable_vddio, enable_inp_h, hold_h, ready}, 32'b0000010);
        chk("rst_pad", {pad_do, pad_oe, core_in}, 32'h0);

        rst_n = 1'b1;
        pwr_good = 1'b1;
        e_h = -1; e_rail = -1; e_inp = -1; e_rdy = -1;
        for (int e = 1; e <= 60; e++) begin
            cyc();
            if (enable_h && e_h < 0) e_h = e;
            if (enable_vddio && e_rail < 0) e_rail = e;
            if (enable_inp_h && e_inp < 0) e_inp = e;
            if (ready && e_rdy < 0) e_rdy = e;
            if (pad_oe != '0) chk("pwrup_pad_oe", 32'(pad_oe), 32'h0);
        end
        chk("edge_enable_h", e_h, 1);
        chk("edge_rail", e_rail, 17);
        chk("edge_inp", e_inp, 33);
        chk("edge_ready", e_rdy, 49);

        foreach (tbl[i]) begin
            core_out = tbl[i].co;
            core_oe  = tbl[i].oe;
            hold_req = tbl[i].hr;
            cyc();
            chk($sformatf("tbl%0d_do", i), 32'(pad_do), 32'(tbl[i].edo));
            chk($sformatf("tbl%0d_oe", i), 32'(pad_oe), 32'(tbl[i].eoe));
            chk($sformatf("tbl%0d_hold_h", i), 32'(hold_h), 32'(tbl[i].ehh));
            chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].erdy));
        end

        pad_in[0] = 1'b1;
        repeat (5) cyc();
        pad_in[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (core_in[0]) chk("glitch_core_in0", 32'(core_in[0]), 32'h0);
        end
        chk("glitch_core_in0_end", 32'(core_in[0]), 32'h0);
        pad_in[0] = 1'b1;
        first = -1;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (core_in[0] && first < 0) first = k;
        end
        chk("deb_latency", first, 10);

        core_oe = 8'hFF;
        cyc();
        cyc();
        chk("pre_rst_pad_oe", 32'(pad_oe), 32'hFF);
        rst_n = 1'b0;
        cyc();
        chk("rst_active_pad_oe", 32'(pad_oe), 32'h0);
        chk("rst_active_core_in", 32'(core_in), 32'h0);
        chk("rst_active_ready", 32'(ready), 32'h0);
        chk("rst_active_hold_h", 32'(hold_h), 32'h1);
        rst_n = 1'b1;

        repeat (20) cyc();
        chk("mid_rail", 32'(enable_vddio), 32'h1);
        pwr_good = 1'b0;
        cyc();
        chk("drop_enables", {enable_h, enable_vdda_h, enable_vswitch_h, enable_vddio, enable_inp_h, ready}, 32'h0);
        pwr_good = 1'b1;
        e_h = -1; e_rail = -1;
        for (int e = 1; e <= 20; e++) begin
            cyc();
            if (enable_h && e_h < 0) e_h = e;
            if (enable_vddio && e_rail < 0) e_rail = e;
        end
        chk("restart_enable_h", e_h, 1);
        chk("restart_rail", e_rail, 17);

        for (int k = 0; k < 3000; k++) begin
            rst_n    = $urandom_range(499) != 0;
            pwr_good = $urandom_range(149) != 0;
            if ($urandom_range(7) == 0) hold_req = ~hold_req;
            core_out = N'($urandom);
            core_oe  = N'($urandom);
            for (int p = 0; p < N; p++) if ($urandom_range(15) == 0) pad_in[p] = ~pad_in[p];
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gpio_pad_ctrl.md
Name: gpio_pad_ctrl

Overview:
Core-side controller for a bank of sky130 GPIOv2 pads. It owns the pad enable-rail power-up sequence and the hold latch. It drives output data and output-enable into the pads. It returns pad inputs to the core after synchronizing and debouncing them. It sits between core logic and the pad-ring instances, one per GPIO bank.

Parameters:
N_PADS, 8, number of pads in the bank
SEQ_STEP_CYCLES, 16, clk cycles spent in each power-up step (>=1)
DEB_CYCLES, 8, consecutive stable synchronized cycles required before core_in updates (>=1)

Ports:
clk  input  1  bank clock
rst_n  input  1  reset, synchronous, active-low
pwr_good  input  1  IO supplies valid; low forces the power-down sequence
hold_req  input  1  request to latch the pad state (sleep)
core_out  input  N_PADS  output data from core
core_oe  input  N_PADS  per-pad output enable from core
core_in  output  N_PADS  synchronized, debounced pad input
pad_do  output  N_PADS  data to pad OUT driver
pad_oe  output  N_PADS  output enable to pad driver
pad_in  input  N_PADS  raw pad IN (asynchronous)
enable_h  output  1  to ENABLE_H
enable_vdda_h  output  1  to ENABLE_VDDA_H
enable_vswitch_h  output  1  to ENABLE_VSWITCH_H
enable_vddio  output  1  to ENABLE_VDDIO
enable_inp_h  output  1  to ENABLE_INP_H
hold_h  output  1  to HOLD_H; 1 = transparent, 0 = pad state latched
ready  output  1  high only in ACTIVE

Behaviour:
- Single clock domain. Reset is synchronous, active-low and takes effect on the clk edge.
- Reset values: all enables 0, hold_h 1, pad_do 0, pad_oe 0, core_in 0, ready 0, FSM in OFF, all counters 0.
- FSM states: OFF, EN_H, EN_RAIL, EN_INP, ACTIVE, HOLD. A step counter runs in EN_H, EN_RAIL and EN_INP.
- OFF -> EN_H: on the first edge where pwr_good=1.
- EN_H: enable_h=1.
- EN_H -> EN_RAIL: after SEQ_STEP_CYCLES cycles in EN_H.
- EN_RAIL: additionally enable_vdda_h=1, enable_vswitch_h=1, enable_vddio=1.
- EN_RAIL -> EN_INP: after SEQ_STEP_CYCLES cycles.
- EN_INP: additionally enable_inp_h=1.
- EN_INP -> ACTIVE: after SEQ_STEP_CYCLES cycles.
- Enables are registered outputs and are cumulative: each state keeps the previous steps' enables asserted.
- ACTIVE: ready=1. Each edge, pad_do<=core_out and pad_oe<=core_oe, giving 1 cycle of latency.
- ACTIVE -> HOLD: when hold_req=1. hold_h=0 from the next edge. pad_do/pad_oe freeze at their last values and core_out/core_oe are ignored. ready=0.
- HOLD -> ACTIVE: when hold_req=0. hold_h=1 on entry. pad_do/pad_oe resume tracking from the following edge.
- hold_req is ignored outside ACTIVE and HOLD.
- pwr_good=0 in any state other than OFF: next edge goes to OFF. All enables 0, hold_h 1, pad_oe 0, pad_do 0, step counter cleared, ready 0.
- pwr_good=0 takes priority over hold_req and over step completion in the same cycle.
- Input path, per pad: a 2-flop synchronizer s1->s2 on pad_in, then a debounce counter.
  - While s2 != core_in, the counter increments.
  - When s2 equals core_in, the counter clears.
  - On the edge where the counter would reach DEB_CYCLES, core_in<=s2 and the counter clears.
  - Latency from a stable pad_in change to core_in is 2+DEB_CYCLES edges.
  - A glitch shorter than DEB_CYCLES synchronized cycles never propagates.
- While enable_inp_h=0, the synchronizers and counters are held at 0 and core_in=0.
- In HOLD the input path keeps running.
- Counter widths: $clog2(SEQ_STEP_CYCLES+1) for the step counter and $clog2(DEB_CYCLES+1) for the debounce counters. Counters saturate and never wrap.

Decomposition:
- Package gpio_pad_pkg holds the FSM state enum (pad_seq_state_t, 3-bit) and the default step and debounce constants.
- One sub-module, gpio_in_deb: single-bit synchronizer plus debounce with its own counter, instantiated N_PADS times via generate.
- The FSM and output registers stay in the top.

Test Plan:
- Reset, then pwr_good=1 at cycle 0 with SEQ_STEP_CYCLES=16 -> enable_h rises at edge 1, the rail enables at edge 17, enable_inp_h at edge 33, ready at edge 49. pad_oe stays 0 throughout.
- In ACTIVE, core_out=0xA5 and core_oe=0x0F -> pad_do=0xA5 and pad_oe=0x0F one edge later.
- hold_req=1, then core_out changes to 0x3C -> hold_h=0 and pad_do stays 0xA5. After hold_req=0, hold_h=1 and pad_do becomes 0x3C one edge after entry to ACTIVE.
- pad_in[0] pulses 1 for 5 cycles with DEB_CYCLES=8 -> core_in[0] stays 0. pad_in[0] held 1 -> core_in[0]=1 exactly 10 edges after the change.
- pwr_good drops mid-EN_RAIL -> next edge all enables 0 and state OFF. pwr_good reasserted -> the full sequence restarts from EN_H with counters cleared.
- rst_n=0 asserted in ACTIVE with pad_oe=0xFF -> after that edge pad_oe=0, core_in=0, ready=0, hold_h=1.
